// File: rtl/load_writeback_if.sv
// Command, data-memory and register-file write-port signals of the load/writeback unit.
// The unit itself takes the slave view; whoever issues loads and models memory takes the master view.
interface load_writeback_if;
    logic        start;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rf_waddr;
    logic        rf_we;
    logic [31:0] rf_wdata;

    modport slave (
        input  start, rd_addr, funct3, addr, mem_ready, mem_rvalid, mem_rdata,
        output busy, done, err, mem_req, mem_addr, rf_waddr, rf_we, rf_wdata
    );

    modport master (
        output start, rd_addr, funct3, addr, mem_ready, mem_rvalid, mem_rdata,
        input  busy, done, err, mem_req, mem_addr, rf_waddr, rf_we, rf_wdata
    );
endinterface

// File: rtl/load_writeback_unit.sv
// Multi-cycle load engine: one word read from data memory, then byte/half extraction
// and a single-cycle register-file write.
module load_writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    load_writeback_if.slave lw
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    function automatic logic legal(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~off[0];
            3'b010:         legal = (off == 2'b00);
            default:        legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'b0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'b0, h};
            default: extract = w;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            waddr_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (lw.start) begin
                    rd_d    = lw.rd_addr;
                    f3_d    = lw.funct3;
                    off_d   = lw.addr[1:0];
                    waddr_d = lw.addr[31:2];
                    if (legal(lw.funct3, lw.addr[1:0])) state_d = REQ;
                    else                                err_d   = 1'b1;
                end
            end
            REQ: begin
                // No timeout here: the memory is allowed to hold off acceptance indefinitely.
                if (lw.mem_ready) begin
                    if (lw.mem_rvalid) begin
                        rdata_d = lw.mem_rdata;
                        state_d = WB;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lw.mem_rvalid) begin
                    rdata_d = lw.mem_rdata;
                    state_d = WB;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only, so reset drops them immediately.
    assign lw.busy     = (state_q != IDLE);
    assign lw.mem_req  = (state_q == REQ);
    assign lw.mem_addr = {waddr_q, 2'b00};
    assign lw.done     = (state_q == WB);
    assign lw.err      = err_q;
    assign lw.rf_we    = (state_q == WB) && (rd_q != 5'd0);
    assign lw.rf_waddr = (state_q == WB) ? rd_q : 5'd0;
    assign lw.rf_wdata = (state_q == WB) ? extract(f3_q, off_q, rdata_q) : 32'd0;
endmodule

// File: tb/tb_load_writeback_unit.sv
// Randomized bench for load_writeback_unit: a per-transaction timeline model predicts
// every output each cycle, and directed loads pin the model with hand-computed values.
module tb_load_writeback_unit;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_writeback_if lw ();
    load_writeback_unit #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .lw(lw));

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic        exp_busy, exp_req, exp_done, exp_err, exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata, exp_maddr, cur_maddr;

    int          done_cnt = 0, err_cnt = 0, req_cyc = 0;
    logic [31:0] last_wdata = '0, last_maddr = '0;
    logic [4:0]  last_waddr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [2:0] f3, input logic [1:0] o);
        case (f3)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return (o % 2) == 0;
            3'b010:         return o == 0;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] o,
                                             input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * o)) & 32'hFF;
        h = (w >> (16 * (o / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     32'(lw.busy),     32'(exp_busy));
            chk("mem_req",  32'(lw.mem_req),  32'(exp_req));
            chk("mem_addr", lw.mem_addr,      exp_maddr);
            chk("done",     32'(lw.done),     32'(exp_done));
            chk("err",      32'(lw.err),      32'(exp_err));
            chk("rf_we",    32'(lw.rf_we),    32'(exp_we));
            chk("rf_waddr", 32'(lw.rf_waddr), 32'(exp_waddr));
            chk("rf_wdata", lw.rf_wdata,      exp_wdata);
        end
        if (lw.done) begin
            done_cnt   <= done_cnt + 1;
            last_wdata <= lw.rf_wdata;
            last_waddr <= lw.rf_waddr;
            last_maddr <= lw.mem_addr;
        end
        if (lw.err)     err_cnt <= err_cnt + 1;
        if (lw.mem_req) req_cyc <= req_cyc + 1;
    end

    task automatic set_idle_exp();
        exp_busy = 0; exp_req = 0; exp_done = 0; exp_err = 0; exp_we = 0;
        exp_waddr = '0; exp_wdata = '0; exp_maddr = cur_maddr;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        lw.start = 0;
        lw.mem_ready = 1'($urandom_range(1));
        lw.mem_rvalid = 1'($urandom_range(1));
        lw.mem_rdata = $urandom;
        set_idle_exp();
        @(negedge clk); #1;
    endtask

    // R = cycles mem_ready is held low in REQ; V = cycles from acceptance to rvalid (0 = same cycle).
    task automatic run_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rdata, input int R, input int V);
        bit ok, busy_c;
        logic [31:0] val;
        int acc, wb, errc, last;
        ok  = ref_legal(f3, a[1:0]);
        val = ref_load(f3, a[1:0], rdata);
        acc = 1 + R;
        wb = -1; errc = -1;
        if (!ok)           errc = 1;
        else if (V == 0)   wb = acc + 1;
        else if (V <= TMO) wb = acc + V + 1;
        else               errc = acc + TMO + 1;
        last = (wb >= 0) ? wb : errc;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            busy_c = ok && c >= 1 && c != errc;
            if (c == 0) begin
                lw.start = 1; lw.rd_addr = rd; lw.funct3 = f3; lw.addr = a;
            end else begin
                lw.start = busy_c && ($urandom_range(1) == 1);
                lw.rd_addr = 5'($urandom); lw.funct3 = 3'($urandom); lw.addr = $urandom;
            end
            if (ok && c >= 1 && c < acc) lw.mem_ready = 0;
            else if (ok && c == acc)     lw.mem_ready = 1;
            else                         lw.mem_ready = 1'($urandom_range(1));
            if (ok && ((V == 0 && c == acc) || (V > 0 && V <= TMO && c == acc + V))) begin
                lw.mem_rvalid = 1; lw.mem_rdata = rdata;
            end else begin
                lw.mem_rvalid = (!ok || c < acc) ? 1'($urandom_range(1)) : 1'b0;
                lw.mem_rdata = $urandom;
            end
            if (c == 1) cur_maddr = {a[31:2], 2'b00};
            exp_maddr = cur_maddr;
            exp_busy  = busy_c;
            exp_req   = ok && c >= 1 && c <= acc;
            exp_done  = (c == wb);
            exp_we    = (c == wb) && rd != 0;
            exp_waddr = (c == wb) ? rd : 5'd0;
            exp_wdata = (c == wb) ? val : 32'd0;
            exp_err   = (c == errc);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        int d0, e0, r0, R, V;
        logic [31:0] a;
        lw.start = 0; lw.rd_addr = '0; lw.funct3 = '0; lw.addr = '0;
        lw.mem_ready = 0; lw.mem_rvalid = 0; lw.mem_rdata = '0;
        cur_maddr = '0;
        set_idle_exp();
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        run_load(5'd5, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0);
        chk("lw_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("lw_waddr", 32'(last_waddr), 32'd5);
        chk("lw_maddr", last_maddr, 32'h0000_1004);

        run_load(5'd7, 3'b000, 32'h0000_2003, 32'h80FF_1234, 0, 0);
        chk("lb_wdata", last_wdata, 32'hFFFF_FF80);
        chk("lb_maddr", last_maddr, 32'h0000_2000);
        run_load(5'd7, 3'b100, 32'h0000_2003, 32'h80FF_1234, 0, 0);
        chk("lbu_wdata", last_wdata, 32'h0000_0080);

        r0 = req_cyc; d0 = done_cnt;
        run_load(5'd4, 3'b001, 32'h0000_0102, 32'h9ABC_5678, 3, 2);
        chk("lh_wdata", last_wdata, 32'hFFFF_9ABC);
        chk("lh_req_cycles", 32'(req_cyc - r0), 32'd4);
        chk("lh_maddr", last_maddr, 32'h0000_0100);
        chk("lh_one_done", 32'(done_cnt - d0), 32'd1);

        e0 = err_cnt; r0 = req_cyc; d0 = done_cnt;
        run_load(5'd6, 3'b010, 32'h0000_0006, $urandom, 0, 0);
        run_load(5'd6, 3'b011, 32'h0000_0100, $urandom, 0, 0);
        chk("illegal_err", 32'(err_cnt - e0), 32'd2);
        chk("illegal_no_req", 32'(req_cyc - r0), 32'd0);
        chk("illegal_no_done", 32'(done_cnt - d0), 32'd0);

        e0 = err_cnt; d0 = done_cnt;
        run_load(5'd2, 3'b010, 32'h0000_0040, $urandom, 1, TMO + 2);
        chk("timeout_err", 32'(err_cnt - e0), 32'd1);
        chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);

        run_load(5'd0, 3'b000, 32'h0000_0011, 32'h0000_AB00, 0, 1);
        chk("x0_wdata", last_wdata, 32'hFFFF_FFAB);
        chk("x0_waddr", 32'(last_waddr), 32'd0);

        // Reset while waiting for read data; the late rvalid must be dropped.
        chk_en = 0;
        @(posedge clk); #1;
        lw.start = 1; lw.rd_addr = 5'd3; lw.funct3 = 3'b010; lw.addr = 32'h40;
        lw.mem_ready = 0; lw.mem_rvalid = 0;
        @(posedge clk); #1;
        lw.start = 0; lw.mem_ready = 1;
        @(posedge clk); #1;
        lw.mem_ready = 0;
        chk("pre_rst_busy", 32'(lw.busy), 32'd1);
        #2 rst = 1;
        #1;
        chk("rst_wait_busy", 32'(lw.busy), 32'd0);
        chk("rst_wait_req", 32'(lw.mem_req), 32'd0);
        chk("rst_wait_we", 32'(lw.rf_we), 32'd0);
        chk("rst_maddr", lw.mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 0; lw.mem_rvalid = 1; lw.mem_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("late_rvalid_we", 32'(lw.rf_we), 32'd0);
        chk("late_rvalid_done", 32'(lw.done), 32'd0);
        @(posedge clk); #1;
        lw.mem_rvalid = 0;
        @(negedge clk);
        chk("late_rvalid_we2", 32'(lw.rf_we), 32'd0);
        chk("late_rvalid_busy", 32'(lw.busy), 32'd0);
        cur_maddr = '0;
        set_idle_exp();
        chk_en = 1;
        run_load(5'd12, 3'b101, 32'h0000_0302, 32'hF00D_8001, 1, 1);
        chk("after_rst_wdata", last_wdata, 32'h0000_F00D);

        // Reset during the writeback cycle: the write must vanish at once.
        chk_en = 0;
        @(posedge clk); #1;
        lw.start = 1; lw.rd_addr = 5'd9; lw.funct3 = 3'b010; lw.addr = 32'h80;
        lw.mem_ready = 0; lw.mem_rvalid = 0;
        @(posedge clk); #1;
        lw.start = 0; lw.mem_ready = 1; lw.mem_rvalid = 1; lw.mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        lw.mem_ready = 0; lw.mem_rvalid = 0;
        chk("pre_rst_we", 32'(lw.rf_we), 32'd1);
        #2 rst = 1;
        #1;
        chk("rst_wb_we", 32'(lw.rf_we), 32'd0);
        chk("rst_wb_done", 32'(lw.done), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        cur_maddr = '0;
        set_idle_exp();
        chk_en = 1;

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(1) == 1) a[1:0] = 2'b00;
            R = $urandom_range(3);
            V = $urandom_range(TMO + 2);
            run_load(5'($urandom), 3'($urandom), a, $urandom, R, V);
            if ($urandom_range(3) == 0) idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/load_writeback_unit.md
Name: load_writeback_unit

Overview:
- Multi-cycle load engine for the CPU.
- Accepts a load command (rd, funct3, byte address) and issues a single word read to data memory over a req/ready + rvalid handshake.
- Byte-aligns and sign/zero-extends the returned word, then drives the register file write port (waddr/we/wdata) for exactly one cycle.
- It is the writer end of the register file's write port; the register file ignores writes to x0, and this block also suppresses them.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT without mem_rvalid before abort with err; range 1..65535.

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous active-high reset
start  input  1  load command valid; sampled only in IDLE
rd_addr  input  5  destination register
funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
addr  input  32  effective byte address
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the load completes successfully
err  output  1  one-cycle pulse on illegal funct3, misalignment or timeout
mem_req  output  1  read request, held until accepted
mem_addr  output  32  word address: {addr[31:2], 2'b00}
mem_ready  input  1  memory accepts request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data, little-endian word
rf_waddr  output  5  register file write address
rf_we  output  1  register file write enable
rf_wdata  output  32  register file write data

Behaviour:
- States: IDLE, REQ, WAIT, WB. Reset (async, any state) -> IDLE. All outputs are 0 in reset and while IDLE, except mem_addr, which holds the latched value (0 after reset).
- IDLE:
  - On start=1, latch rd_addr, funct3, addr[1:0] and the word address.
  - Illegal funct3 (011, 110, 111), LH/LHU with addr[0]=1, or LW with addr[1:0]!=0: pulse err next cycle, stay IDLE, no mem_req, no write.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1 with mem_addr stable until the cycle mem_ready=1.
  - mem_ready=1 and mem_rvalid=0: go to WAIT and clear the timeout counter.
  - mem_ready=1 and mem_rvalid=1 in the same cycle: capture mem_rdata and go straight to WB.
  - mem_ready=0: stay in REQ with no timeout (the memory owns backpressure).
- WAIT:
  - Counter increments every cycle.
  - mem_rvalid=1: capture mem_rdata, go to WB.
  - Counter reaches TIMEOUT_CYCLES with no rvalid: pulse err, go to IDLE, no write.
- WB (exactly one cycle):
  - rf_waddr=latched rd, rf_wdata=extracted value, done=1, then IDLE.
  - rf_we=1 only if rd!=0. For rd=0, done still pulses and rf_we stays 0.
- Extraction, using the byte offset o = latched addr[1:0]:
  - Byte = rdata[8*o+7:8*o]. LB sign-extends bit 7, LBU zero-extends.
  - Half = rdata[16*o[1]+15:16*o[1]]. LH sign-extends bit 15, LHU zero-extends.
  - LW passes the word through.
- Data capture: mem_rdata is registered on capture. It is never sampled combinationally into WB, so rf_wdata is independent of mem_rdata during WB.
- Latency: start in cycle 0 -> mem_req in cycle 1 -> earliest rf_we in cycle 2 (ready and rvalid together in cycle 1). Each additional ready or rvalid wait cycle adds one.
- start while busy=1 is ignored and not queued. mem_rvalid in IDLE or REQ (before acceptance) is ignored.
- Reset mid-operation:
  - mem_req and rf_we drop immediately (asynchronously); no write and no done.
  - A late mem_rvalid after reset is ignored.
- done and err are never high in the same cycle.

Test Plan:
- LW: start, addr=0x0000_1004, rd=5, funct3=010; mem_ready=1 and rvalid=1 in cycle 1, rdata=0xDEAD_BEEF -> cycle 2: rf_we=1, rf_waddr=5, rf_wdata=0xDEAD_BEEF, done=1; mem_addr=0x0000_1004.
- LB vs LBU: addr=0x0000_2003, rdata=0x80FF_1234. LB rd=7 -> rf_wdata=0xFFFF_FF80. LBU -> 0x0000_0080. mem_addr=0x0000_2000 in both cases.
- LH with backpressure: addr=0x0000_0102, rdata=0x9ABC_5678; mem_ready low 3 cycles, rvalid 2 cycles after acceptance -> mem_req high 4 cycles with stable mem_addr=0x0000_0100; rf_wdata=0xFFFF_9ABC.
- Errors:
  - LW addr=0x0000_0006 -> err pulse next cycle, mem_req never asserted, rf_we=0.
  - funct3=011 -> same response.
  - start asserted while busy -> ignored.
- Timeout and x0: TIMEOUT_CYCLES=4, rvalid never arrives -> err after 4 WAIT cycles, back to IDLE, no write. Separately, a load to rd=0 -> done=1, rf_we=0.
- Reset mid-WAIT: assert rst asynchronously -> busy, mem_req and rf_we go 0 immediately. A later rvalid with rdata=0x1111_1111 produces no write; the next load completes normally.
